// File: rtl/pollard_mod_sequencer_if.sv
// Job/result handshake and reduction-unit bus for the Pollard p-1 modular sequencer.
interface pollard_mod_sequencer_if #(
    parameter int unsigned CNT_W = 32
);
    logic              jobValid;
    logic              jobReady;
    logic [63:0]       jobExponent;
    logic [63:0]       jobNumber;
    logic              resultValid;
    logic              resultReady;
    logic [63:0]       result;
    logic              resultError;
    logic [CNT_W-1:0]  cycleCount;
    logic              modStart;
    logic              modReset;
    logic [63:0]       modExponent;
    logic [63:0]       modNumber;
    logic [7:0]        modLogNum;
    logic [63:0]       modResult;
    logic              modIsDone;

    // Host side: issues jobs, consumes results, plays the reduction unit.
    modport master (
        output jobValid, jobExponent, jobNumber, resultReady, modResult, modIsDone,
        input  jobReady, resultValid, result, resultError, cycleCount,
               modStart, modReset, modExponent, modNumber, modLogNum
    );

    // Sequencer side.
    modport slave (
        input  jobValid, jobExponent, jobNumber, resultReady, modResult, modIsDone,
        output jobReady, resultValid, result, resultError, cycleCount,
               modStart, modReset, modExponent, modNumber, modLogNum
    );
endinterface

// File: rtl/pollard_mod_sequencer.sv
// Initiator-side controller for the iterative 2^e mod n reduction unit.
// Finds floor(log2(n)) serially, resolves short exponents directly and
// otherwise runs the unit's start/reset/isDone protocol. All outputs registered.
module pollard_mod_sequencer #(
    parameter int unsigned MAX_EXP = 1000,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    pollard_mod_sequencer_if.slave bus
);
    localparam int unsigned DATA_W = 64;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned LOG_W  = 8;

    localparam logic [2:0] ST_FLUSH   = 3'd0;
    localparam logic [2:0] ST_IDLE    = 3'd1;
    localparam logic [2:0] ST_LOG     = 3'd2;
    localparam logic [2:0] ST_DECIDE  = 3'd3;
    localparam logic [2:0] ST_WAIT    = 3'd4;
    localparam logic [2:0] ST_ACK     = 3'd5;
    localparam logic [2:0] ST_CAPTURE = 3'd6;
    localparam logic [2:0] ST_RESP    = 3'd7;

    logic [2:0]        state_q,     state_d;
    logic [DATA_W-1:0] exp_q,       exp_d;
    logic [DATA_W-1:0] num_q,       num_d;
    logic [IDX_W-1:0]  idx_q,       idx_d;
    logic [IDX_W-1:0]  log_q,       log_d;
    logic              draining_q,  draining_d;

    logic              job_ready_q,    job_ready_d;
    logic              result_valid_q, result_valid_d;
    logic [DATA_W-1:0] result_q,       result_d;
    logic              result_error_q, result_error_d;
    logic [CNT_W-1:0]  cycle_count_q,  cycle_count_d;
    logic              mod_start_q,    mod_start_d;
    logic              mod_reset_q,    mod_reset_d;
    logic [DATA_W-1:0] mod_exponent_q, mod_exponent_d;
    logic [DATA_W-1:0] mod_number_q,   mod_number_d;
    logic [LOG_W-1:0]  mod_log_num_q,  mod_log_num_d;

    // 2^e for the direct path; only meaningful when e <= logNum <= 63.
    logic [DATA_W-1:0] direct_pow;
    assign direct_pow = DATA_W'(1) << exp_q[IDX_W-1:0];

    // Next-state and next-output logic; outputs follow the state being entered.
    always_comb begin
        state_d        = state_q;
        exp_d          = exp_q;
        num_d          = num_q;
        idx_d          = idx_q;
        log_d          = log_q;
        draining_d     = draining_q;
        job_ready_d    = job_ready_q;
        result_valid_d = result_valid_q;
        result_d       = result_q;
        result_error_d = result_error_q;
        cycle_count_d  = cycle_count_q;
        mod_start_d    = mod_start_q;
        mod_reset_d    = mod_reset_q;
        mod_exponent_d = mod_exponent_q;
        mod_number_d   = mod_number_q;
        mod_log_num_d  = mod_log_num_q;

        case (state_q)
            ST_FLUSH: begin
                // Let any half-finished unit run to completion on a harmless job.
                job_ready_d    = 1'b0;
                mod_start_d    = 1'b1;
                mod_reset_d    = 1'b0;
                mod_exponent_d = '0;
                mod_number_d   = '1;
                mod_log_num_d  = LOG_W'(DATA_W - 1);
                if (bus.modIsDone) begin
                    mod_reset_d = 1'b1;
                    state_d     = ST_ACK;
                end
            end
            ST_IDLE: begin
                mod_start_d = 1'b0;
                mod_reset_d = 1'b0;
                if (bus.jobValid) begin
                    exp_d         = bus.jobExponent;
                    num_d         = bus.jobNumber;
                    cycle_count_d = '0;
                    job_ready_d   = 1'b0;
                    if ((bus.jobNumber == '0) || (bus.jobExponent > DATA_W'(MAX_EXP))) begin
                        result_d       = '0;
                        result_error_d = 1'b1;
                        result_valid_d = 1'b1;
                        state_d        = ST_RESP;
                    end else begin
                        idx_d   = IDX_W'(DATA_W - 1);
                        state_d = ST_LOG;
                    end
                end
            end
            ST_LOG: begin
                // Leading-one search, MSB first, one bit per cycle.
                if (num_q[idx_q]) begin
                    log_d   = idx_q;
                    state_d = ST_DECIDE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            ST_DECIDE: begin
                if (exp_q <= DATA_W'(log_q)) begin
                    // 2^e <= n: only the power-of-two equality case wraps to zero.
                    result_d       = (direct_pow == num_q) ? '0 : direct_pow;
                    result_error_d = 1'b0;
                    result_valid_d = 1'b1;
                    state_d        = ST_RESP;
                end else begin
                    mod_exponent_d = exp_q;
                    mod_number_d   = num_q;
                    mod_log_num_d  = LOG_W'(log_q);
                    mod_start_d    = 1'b1;
                    mod_reset_d    = 1'b0;
                    state_d        = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cycle_count_q != '1) begin
                    cycle_count_d = cycle_count_q + CNT_W'(1);
                end
                if (bus.modIsDone) begin
                    mod_reset_d = 1'b1;
                    state_d     = ST_ACK;
                end
            end
            ST_ACK: begin
                // Unit publishes and clears on this edge; drop start so it stays idle.
                mod_start_d = 1'b0;
                mod_reset_d = 1'b0;
                if (draining_q) begin
                    draining_d  = 1'b0;
                    job_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // The unit stops subtracting at equality, so n itself means zero.
                result_d       = (bus.modResult == num_q) ? '0 : bus.modResult;
                result_error_d = 1'b0;
                result_valid_d = 1'b1;
                state_d        = ST_RESP;
            end
            ST_RESP: begin
                if (bus.resultReady) begin
                    result_valid_d = 1'b0;
                    result_error_d = 1'b0;
                    job_ready_d    = 1'b1;
                    state_d        = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_FLUSH;
            end
        endcase
    end

    // State and output registers; reset lands in FLUSH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_FLUSH;
            exp_q          <= '0;
            num_q          <= '0;
            idx_q          <= '0;
            log_q          <= '0;
            draining_q     <= 1'b1;
            job_ready_q    <= 1'b0;
            result_valid_q <= 1'b0;
            result_q       <= '0;
            result_error_q <= 1'b0;
            cycle_count_q  <= '0;
            mod_start_q    <= 1'b0;
            mod_reset_q    <= 1'b0;
            mod_exponent_q <= '0;
            mod_number_q   <= '1;
            mod_log_num_q  <= '0;
        end else begin
            state_q        <= state_d;
            exp_q          <= exp_d;
            num_q          <= num_d;
            idx_q          <= idx_d;
            log_q          <= log_d;
            draining_q     <= draining_d;
            job_ready_q    <= job_ready_d;
            result_valid_q <= result_valid_d;
            result_q       <= result_d;
            result_error_q <= result_error_d;
            cycle_count_q  <= cycle_count_d;
            mod_start_q    <= mod_start_d;
            mod_reset_q    <= mod_reset_d;
            mod_exponent_q <= mod_exponent_d;
            mod_number_q   <= mod_number_d;
            mod_log_num_q  <= mod_log_num_d;
        end
    end

    assign bus.jobReady    = job_ready_q;
    assign bus.resultValid = result_valid_q;
    assign bus.result      = result_q;
    assign bus.resultError = result_error_q;
    assign bus.cycleCount  = cycle_count_q;
    assign bus.modStart    = mod_start_q;
    assign bus.modReset    = mod_reset_q;
    assign bus.modExponent = mod_exponent_q;
    assign bus.modNumber   = mod_number_q;
    assign bus.modLogNum   = mod_log_num_q;
endmodule

// File: tb/tb_pollard_mod_sequencer.sv
// Directed bench for pollard_mod_sequencer with a behavioural reduction unit.
module tb_pollard_mod_sequencer;
    localparam int unsigned CNT_W    = 32;
    localparam int          UNIT_LAT = 3;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   start_cycles;

    pollard_mod_sequencer_if #(.CNT_W(CNT_W)) bus ();

    pollard_mod_sequencer #(.MAX_EXP(1000), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reduction unit: 2^e mod n by doubling, reporting n instead of 0.
    function automatic logic [63:0] unit_model(input logic [63:0] e, input logic [63:0] n);
        logic [64:0] r;
        r = 65'd1;
        for (int i = 0; 64'(i) < e; i++) begin
            r = r << 1;
            if (r >= {1'b0, n}) r = r - {1'b0, n};
        end
        if (r == 65'd0) r = {1'b0, n};
        return r[63:0];
    endfunction

    logic        u_busy = 1'b0;
    logic        u_done = 1'b0;
    int          u_cnt  = 0;
    logic [63:0] u_val  = '0;
    logic [63:0] u_out  = '0;
    assign bus.modIsDone = u_done;
    assign bus.modResult = u_out;

    always @(posedge clk) begin
        if (bus.modStart && bus.modReset && u_done) begin
            u_out  <= u_val;
            u_done <= 1'b0;
            u_busy <= 1'b0;
        end else if (bus.modStart && !u_busy && !u_done) begin
            u_busy <= 1'b1;
            u_cnt  <= UNIT_LAT;
            u_val  <= unit_model(bus.modExponent, bus.modNumber);
        end else if (u_busy) begin
            if (u_cnt == 1) begin
                u_busy <= 1'b0;
                u_done <= 1'b1;
            end else begin
                u_cnt <= u_cnt - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (bus.modStart) start_cycles <= start_cycles + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Offer a job from a negedge; returns at a negedge after acceptance.
    task automatic send_job(input logic [63:0] e, input logic [63:0] n, output logic ok);
        ok = 1'b0;
        bus.jobExponent = e;
        bus.jobNumber   = n;
        bus.jobValid    = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (bus.jobReady) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus.jobValid = 1'b0;
    endtask

    task automatic wait_result(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (bus.resultValid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic handshake();
        bus.resultReady = 1'b1;
        @(negedge clk);
        bus.resultReady = 1'b0;
    endtask

    task automatic test_reset();
        logic ok;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.jobReady !== 1'b0 || bus.resultValid !== 1'b0 || bus.resultError !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got rdy=%b vld=%b err=%b want 0 0 0", bus.jobReady, bus.resultValid, bus.resultError);
        end
        checks++;
        if (bus.result !== 64'd0 || bus.cycleCount !== 32'd0) begin
            errors++;
            $display("FAIL reset_data got result=%0d count=%0d want 0 0", bus.result, bus.cycleCount);
        end
        checks++;
        if (bus.modStart !== 1'b0 || bus.modReset !== 1'b0 || bus.modExponent !== 64'd0 || bus.modLogNum !== 8'd0) begin
            errors++;
            $display("FAIL reset_mod got start=%b rst=%b exp=%0d log=%0d want 0 0 0 0", bus.modStart, bus.modReset, bus.modExponent, bus.modLogNum);
        end
        checks++;
        if (bus.modNumber !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL reset_modnumber got %h want ffffffffffffffff", bus.modNumber);
        end
        reset = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.jobReady) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL flush_ready got jobReady=%b want 1 within 50 cycles", bus.jobReady);
        end
    endtask

    // One full job with result/error/count expectations; snap guards modStart.
    task automatic run_job(input string name, input logic [63:0] e, input logic [63:0] n,
                           input logic [63:0] exp_res, input logic exp_err,
                           input logic exp_launch, input logic [31:0] exp_cnt);
        logic ok;
        int   snap;
        snap = start_cycles;
        send_job(e, n, ok);
        if (ok) wait_result(ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout got no result want resultValid", name);
        end else begin
            checks++;
            if (bus.result !== exp_res || bus.resultError !== exp_err) begin
                errors++;
                $display("FAIL %s_result got %0d err=%b want %0d err=%b", name, bus.result, bus.resultError, exp_res, exp_err);
            end
            checks++;
            if ((start_cycles != snap) !== exp_launch) begin
                errors++;
                $display("FAIL %s_launch got %b want %b", name, start_cycles != snap, exp_launch);
            end
            if (exp_launch) begin
                checks++;
                if (bus.cycleCount !== exp_cnt) begin
                    errors++;
                    $display("FAIL %s_count got %0d want %0d", name, bus.cycleCount, exp_cnt);
                end
            end
            handshake();
            checks++;
            if (bus.resultValid !== 1'b0 || bus.resultError !== 1'b0 || bus.jobReady !== 1'b1) begin
                errors++;
                $display("FAIL %s_release got vld=%b err=%b rdy=%b want 0 0 1", name, bus.resultValid, bus.resultError, bus.jobReady);
            end
        end
    endtask

    task automatic test_unit_path();
        run_job("unit_5_7", 64'd5, 64'd7, 64'd4, 1'b0, 1'b1, 32'd5);
        checks++;
        if (bus.modLogNum !== 8'd2 || bus.modExponent !== 64'd5 || bus.modNumber !== 64'd7) begin
            errors++;
            $display("FAIL unit_5_7_modbus got log=%0d exp=%0d n=%0d want 2 5 7", bus.modLogNum, bus.modExponent, bus.modNumber);
        end
        run_job("unit_1000_7", 64'd1000, 64'd7, 64'd2, 1'b0, 1'b1, 32'd5);
    endtask

    task automatic test_direct();
        run_job("direct_2_7", 64'd2, 64'd7, 64'd4, 1'b0, 1'b0, 32'd0);
        run_job("direct_3_8", 64'd3, 64'd8, 64'd0, 1'b0, 1'b0, 32'd0);
        run_job("direct_63_max", 64'd63, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic test_equality_fixup();
        run_job("fixup_4_8", 64'd4, 64'd8, 64'd0, 1'b0, 1'b1, 32'd5);
    endtask

    task automatic test_errors();
        run_job("err_n0", 64'd5, 64'd0, 64'd0, 1'b1, 1'b0, 32'd0);
        run_job("err_e1001", 64'd1001, 64'd7, 64'd0, 1'b1, 1'b0, 32'd0);
    endtask

    task automatic test_back_to_back();
        logic ok;
        logic held;
        send_job(64'd5, 64'd7, ok);
        if (ok) wait_result(ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_timeout got no result want resultValid");
        end else begin
            bus.jobExponent = 64'd10;
            bus.jobNumber   = 64'd1000;
            bus.jobValid    = 1'b1;
            held = 1'b1;
            for (int i = 0; i < 10; i++) begin
                if (bus.result !== 64'd4 || bus.resultValid !== 1'b1 || bus.jobReady !== 1'b0) held = 1'b0;
                @(negedge clk);
            end
            checks++;
            if (held !== 1'b1) begin
                errors++;
                $display("FAIL b2b_hold got result=%0d vld=%b rdy=%b want 4 1 0", bus.result, bus.resultValid, bus.jobReady);
            end
            bus.resultReady = 1'b1;
            checks++;
            if (bus.jobReady !== 1'b0) begin
                errors++;
                $display("FAIL b2b_ready_before got %b want 0", bus.jobReady);
            end
            @(negedge clk);
            bus.resultReady = 1'b0;
            checks++;
            if (bus.jobReady !== 1'b1 || bus.resultValid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_ready_after got rdy=%b vld=%b want 1 0", bus.jobReady, bus.resultValid);
            end
            @(negedge clk);
            bus.jobValid = 1'b0;
            wait_result(ok);
            checks++;
            if (ok !== 1'b1 || bus.result !== 64'd24 || bus.resultError !== 1'b0) begin
                errors++;
                $display("FAIL b2b_second got ok=%b result=%0d err=%b want 1 24 0", ok, bus.result, bus.resultError);
            end
            if (ok) handshake();
        end
    endtask

    task automatic test_reset_during_wait();
        logic ok;
        logic acked;
        send_job(64'd5, 64'd7, ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.modStart) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL rst_wait_enter got modStart=0 want 1");
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (bus.modStart !== 1'b0 || bus.jobReady !== 1'b0 || bus.resultValid !== 1'b0 ||
            bus.cycleCount !== 32'd0 || bus.modNumber !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL rst_wait_clear got start=%b rdy=%b vld=%b cnt=%0d n=%h want 0 0 0 0 all-ones",
                     bus.modStart, bus.jobReady, bus.resultValid, bus.cycleCount, bus.modNumber);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        acked = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.modStart && bus.modReset) begin
                acked = 1'b1;
                break;
            end
        end
        checks++;
        if (acked !== 1'b1) begin
            errors++;
            $display("FAIL rst_flush_ack got no ACK want ACK within 4 cycles");
        end
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.jobReady) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready got jobReady=0 want 1");
        end
        run_job("rst_next_5_7", 64'd5, 64'd7, 64'd4, 1'b0, 1'b1, 32'd5);
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        start_cycles    = 0;
        reset           = 1'b0;
        bus.jobValid    = 1'b0;
        bus.jobExponent = '0;
        bus.jobNumber   = '0;
        bus.resultReady = 1'b0;
        test_reset();
        test_unit_path();
        test_direct();
        test_equality_fixup();
        test_errors();
        test_back_to_back();
        test_reset_during_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pollard_mod_sequencer.md
Name: pollard_mod_sequencer

Overview:
- Initiator-side controller for the iterative 2^e mod n reduction unit used in the Pollard p-1 datapath.
- Accepts (exponent, number) jobs over a valid/ready handshake and computes logNum = floor(log2(number)) serially.
- Short exponents are resolved directly; all others drive the unit's start/reset/isDone protocol, capture its result and correct the result == number corner case.
- Returns result, error flag and busy-cycle count over a valid/ready handshake.

Parameters:
- MAX_EXP, 1000: largest exponent accepted; must stay below the unit's 1001-bit internal accumulator.
- CNT_W, 32: width of the cycle counter, which saturates.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state when 0.
- jobValid  in  1  job present.
- jobReady  out  1  sequencer can accept a job.
- jobExponent  in  64  exponent e.
- jobNumber  in  64  modulus n.
- resultValid  out  1  result present.
- resultReady  in  1  consumer accepts the result.
- result  out  64  2^e mod n.
- resultError  out  1  job rejected.
- cycleCount  out  CNT_W  cycles spent in WAIT for this job.
- modStart  out  1  to unit start.
- modReset  out  1  to unit synchronous clear, honoured only while start=1 and isDone=1.
- modExponent  out  64  to unit.
- modNumber  out  64  to unit.
- modLogNum  out  8  to unit.
- modResult  in  64  from unit outputResult.
- modIsDone  in  1  from unit isDone.

Behaviour:
- All outputs are registered (Moore).
- Reset values: all outputs 0, except modNumber = all-ones; state = FLUSH.
- FLUSH:
  - Drives modStart=1, modExponent=0, modNumber=all-ones.
  - On modIsDone=1, go to ACK, then return to IDLE instead of CAPTURE.
  - jobReady stays 0 throughout.
- IDLE:
  - jobReady=1.
  - On jobValid, latch exponent and number, clear cycleCount, set jobReady=0.
  - If number=0 or exponent>MAX_EXP: result=0, resultError=1, go to RESP.
  - Otherwise go to LOG with idx=63.
- LOG:
  - One bit per cycle: if number[idx]=1, logNum=idx and go to DECIDE; else idx decrements.
  - Latency is 64-logNum cycles.
- DECIDE:
  - If exponent <= logNum (direct path; modStart never asserted):
    - 2^e < n: result = 1<<e.
    - 2^e == n: result = 0.
    - Go to RESP.
  - Otherwise drive modExponent, modNumber and modLogNum, then go to WAIT.
- WAIT:
  - modStart=1, modReset=0.
  - cycleCount increments each cycle and saturates at all-ones.
  - When modIsDone=1 is sampled, go to ACK.
- ACK (1 cycle):
  - modStart=1, modReset=1.
  - At this edge the unit copies its result to modResult and clears itself.
- CAPTURE (1 cycle):
  - modStart=0 so the unit does not relaunch.
  - Latch modResult.
  - If modResult == number, result = 0 (the unit stops at equality); otherwise result = modResult.
- RESP:
  - resultValid=1; result, resultError and cycleCount are held stable.
  - On resultReady=1, drop resultValid, clear resultError, go to IDLE.
  - A new job can be accepted no earlier than the cycle after the handshake.
- Width rule: exponent comparisons are unsigned 64-bit; logNum is always <= 63 and zero-extended.
- jobValid is ignored outside IDLE.
- resultReady is ignored outside RESP.
- Async reset at any point:
  - Immediate clear to the reset values and entry to FLUSH.
  - FLUSH drains a partially computed unit by subtracting all-ones chunks; its completion bounds the first jobReady after reset.

Test Plan:
- e=5, n=7 -> logNum 2, unit launched, result 4, resultError 0, cycleCount >= 1.
- e=2, n=7 -> direct path, modStart never 1, result 4; e=3, n=8 -> direct path, result 0.
- e=4, n=8 -> unit stops at 8, CAPTURE fixup gives result 0, resultError 0.
- n=0 (any e), then e=1001 with n=7 -> each gives resultValid with resultError=1, result 0, modStart never 1.
- Two back-to-back jobs (e=5, n=7; e=10, n=1000), resultReady held 0 for 10 cycles -> result 4 held stable, jobReady 0 until the handshake, second result 24.
- reset low for 2 cycles during WAIT of e=5, n=7 -> outputs zero immediately, FLUSH ACKs the unit within 4 cycles, jobReady returns 1, next job e=5, n=7 gives result 4.
